// File: rtl/mioc_od_pkg.sv
// Shared types and default parameters for the mioc open-drain receiver.
package mioc_od_pkg;

    // Default glitch-filter length, in consecutive samples
    localparam int unsigned FILT_LEN_DEF = 3;
    // Default pulse-width counter width
    localparam int unsigned CNT_W_DEF    = 8;
    // Filter run counter width; wide enough for the largest legal FILT_LEN
    localparam int unsigned FILT_CNT_W   = 4;

    // Measurement FSM: waiting for a fall, or timing a low pulse
    typedef enum logic {
        IDLE = 1'b0,
        LOW  = 1'b1
    } rx_state_e;

endpackage : mioc_od_pkg

// File: rtl/mioc_od_filt.sv
// Synchronizer, run-length glitch filter and edge strobes for the wired line.
module mioc_od_filt
    import mioc_od_pkg::*;
#(
    parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic filt_out,
    output logic fall_pulse,
    output logic rise_pulse,
    output logic fall_c,
    output logic rise_c
);

    logic                  sync1_q;
    logic                  sync2_q;
    logic                  filt_q;
    logic                  filt_d;
    logic                  fall_q;
    logic                  rise_q;
    logic [FILT_CNT_W-1:0] filt_cnt_q;
    logic [FILT_CNT_W-1:0] filt_cnt_d;
    logic                  mismatch_c;
    logic                  flip_c;

    // Two-flop synchronizer; idles high like the pulled-up line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
        end
    end

    // Flip the filtered level on the FILT_LEN-th consecutive disagreeing sample
    always_comb begin
        mismatch_c = (sync2_q != filt_q);
        flip_c     = mismatch_c && (filt_cnt_q == FILT_CNT_W'(FILT_LEN - 1));
        filt_d     = filt_q;
        filt_cnt_d = filt_cnt_q;
        if (!mismatch_c || flip_c) begin
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + FILT_CNT_W'(1);
        end
        if (flip_c) begin
            filt_d = ~filt_q;
        end
        fall_c = flip_c && filt_q;
        rise_c = flip_c && !filt_q;
    end

    // Filter state and strobes, registered together so strobes align with the new level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_c;
            rise_q     <= rise_c;
        end
    end

    assign filt_out   = filt_q;
    assign fall_pulse = fall_q;
    assign rise_pulse = rise_q;

endmodule : mioc_od_filt

// File: rtl/mioc_od_rx.sv
// Open-drain line receiver: filtered edges plus low-pulse width measurement
// delivered on a valid/ready interface with sticky overrun.
module mioc_od_rx
    import mioc_od_pkg::*;
#(
    parameter int unsigned FILT_LEN = FILT_LEN_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_in,
    output logic             filt_out,
    output logic             fall_pulse,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] width,
    output logic             width_sat,
    output logic             width_valid,
    input  logic             width_ready,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             fall_c;
    logic             rise_c;
    logic             produce_c;

    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] width_d;
    logic             width_sat_q;
    logic             width_sat_d;
    logic             valid_q;
    logic             valid_d;
    logic             ovr_q;
    logic             ovr_d;

    mioc_od_filt #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_in    (line_in),
        .filt_out   (filt_out),
        .fall_pulse (fall_pulse),
        .rise_pulse (rise_pulse),
        .fall_c     (fall_c),
        .rise_c     (rise_c)
    );

    // Measurement FSM: count filtered-low cycles from the fall to the rise, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall_c) begin
                        state_q <= LOW;
                        cnt_q   <= CNT_W'(1);
                        sat_q   <= 1'b0;
                    end
                end
                LOW: begin
                    if (rise_c) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        sat_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A result is produced on the edge that ends a timed low pulse
    assign produce_c = (state_q == LOW) && rise_c;

    // Result/handshake next state: load when the slot is free or being drained, else drop
    always_comb begin
        width_d     = width_q;
        width_sat_d = width_sat_q;
        valid_d     = valid_q;
        ovr_d       = ovr_q;
        if (produce_c && (!valid_q || width_ready)) begin
            width_d     = cnt_q;
            width_sat_d = sat_q;
            valid_d     = 1'b1;
        end else if (valid_q && width_ready) begin
            valid_d = 1'b0;
        end
        if (produce_c && valid_q && !width_ready) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    // Result and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q     <= '0;
            width_sat_q <= 1'b0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            width_q     <= width_d;
            width_sat_q <= width_sat_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign width       = width_q;
    assign width_sat   = width_sat_q;
    assign width_valid = valid_q;
    assign overrun     = ovr_q;

endmodule : mioc_od_rx

// File: tb/tb_mioc_od_rx.sv
// Bench for mioc_od_rx: two instances (8-bit and 4-bit counters) share stimulus and
// are compared every cycle against a sample-history reference model.
module tb_mioc_od_rx;

    localparam int unsigned F    = 3;
    localparam int unsigned CW_A = 8;
    localparam int unsigned CW_B = 4;
    localparam int          MAX_A = (1 << CW_A) - 1;
    localparam int          MAX_B = (1 << CW_B) - 1;

    logic clk         = 1'b0;
    logic rst_n       = 1'b1;
    logic line_in     = 1'b1;
    logic width_ready = 1'b0;
    logic ovr_clr     = 1'b0;

    logic            filt_a, fall_a, rise_a, sat_a, valid_a, ovr_a;
    logic [CW_A-1:0] width_a;
    logic            filt_b, fall_b, rise_b, sat_b, valid_b, ovr_b;
    logic [CW_B-1:0] width_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit samp[$];
    bit m_filt, m_fall, m_rise, m_in_low, m_valid, m_ovr, m_sa, m_sb;
    int m_fall_edge, m_wa, m_wb;

    mioc_od_rx #(.FILT_LEN(F), .CNT_W(CW_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .line_in(line_in),
        .filt_out(filt_a), .fall_pulse(fall_a), .rise_pulse(rise_a),
        .width(width_a), .width_sat(sat_a), .width_valid(valid_a),
        .width_ready(width_ready), .overrun(ovr_a), .ovr_clr(ovr_clr)
    );

    mioc_od_rx #(.FILT_LEN(F), .CNT_W(CW_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .line_in(line_in),
        .filt_out(filt_b), .fall_pulse(fall_b), .rise_pulse(rise_b),
        .width(width_b), .width_sat(sat_b), .width_valid(valid_b),
        .width_ready(width_ready), .overrun(ovr_b), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Filtered level = value of the most recent run of F equal samples among the
    // first n samples consumed; idle-high if no such run exists yet.
    function automatic bit level_after(int n);
        for (int k = n; k >= int'(F); k--) begin
            bit all0 = 1'b1;
            bit all1 = 1'b1;
            for (int j = k - int'(F); j < k; j++) begin
                if (samp[j]) all0 = 1'b0;
                else         all1 = 1'b0;
            end
            if (all0) return 1'b0;
            if (all1) return 1'b1;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        samp.delete();
        m_filt = 1'b1; m_fall = 1'b0; m_rise = 1'b0; m_in_low = 1'b0;
        m_valid = 1'b0; m_ovr = 1'b0; m_sa = 1'b0; m_sb = 1'b0;
        m_fall_edge = 0; m_wa = 0; m_wb = 0;
    endtask

    // Two sync stages mean the edge-e decision sees samples up to e-2
    task automatic model_edge(input bit ln, input bit rdy, input bit clr);
        bit nf;
        bit prod;
        int len;
        samp.push_back(ln);
        nf   = (samp.size() >= 2) ? level_after(samp.size() - 2) : 1'b1;
        m_fall = m_filt && !nf;
        m_rise = !m_filt && nf;
        prod = 1'b0;
        len  = 0;
        if (m_fall) begin
            m_in_low    = 1'b1;
            m_fall_edge = samp.size();
        end
        if (m_rise && m_in_low) begin
            prod     = 1'b1;
            len      = samp.size() - m_fall_edge;
            m_in_low = 1'b0;
        end
        m_filt = nf;
        if (prod && m_valid && !rdy) m_ovr = 1'b1;
        else if (clr)                m_ovr = 1'b0;
        if (prod && (!m_valid || rdy)) begin
            m_valid = 1'b1;
            m_wa = (len > MAX_A) ? MAX_A : len;
            m_sa = (len > MAX_A);
            m_wb = (len > MAX_B) ? MAX_B : len;
            m_sb = (len > MAX_B);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("filt_a",  32'(filt_a),  32'(m_filt));
        chk("fall_a",  32'(fall_a),  32'(m_fall));
        chk("rise_a",  32'(rise_a),  32'(m_rise));
        chk("width_a", 32'(width_a), 32'(m_wa));
        chk("sat_a",   32'(sat_a),   32'(m_sa));
        chk("valid_a", 32'(valid_a), 32'(m_valid));
        chk("ovr_a",   32'(ovr_a),   32'(m_ovr));
        chk("filt_b",  32'(filt_b),  32'(m_filt));
        chk("fall_b",  32'(fall_b),  32'(m_fall));
        chk("rise_b",  32'(rise_b),  32'(m_rise));
        chk("width_b", 32'(width_b), 32'(m_wb));
        chk("sat_b",   32'(sat_b),   32'(m_sb));
        chk("valid_b", 32'(valid_b), 32'(m_valid));
        chk("ovr_b",   32'(ovr_b),   32'(m_ovr));
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge
    task automatic step(input bit ln, input bit rdy, input bit clr);
        @(negedge clk);
        line_in     = ln;
        width_ready = rdy;
        ovr_clr     = clr;
        @(posedge clk);
        #1;
        model_edge(ln, rdy, clr);
        check_all();
    endtask

    initial begin
        int seen;
        int nstrobe;
        int nvalid;
        int capw;
        int capb;
        int caps;

        model_reset();

        // Reset with the line held low
        #1;
        rst_n   = 1'b0;
        line_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all();

        // Release with the line still low: fall must appear on edge F+2
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 1; i <= 20 && seen == 0; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (fall_a === 1'b1) seen = i;
        end
        chk("fall_after_release", 32'(seen), 32'(F + 2));
        repeat (4)  step(1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0);

        // Glitch shorter than F: no level change, no strobes
        nstrobe = 0;
        repeat (6) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step((i == 2 || i == 3) ? 1'b0 : 1'b1, 1'b1, 1'b0);
            if (fall_a === 1'b1 || rise_a === 1'b1 || valid_a === 1'b1) nstrobe++;
        end
        chk("glitch_events", 32'(nstrobe), 32'd0);
        chk("glitch_filt", 32'(filt_a), 32'd1);

        // 10-cycle pulse, consumer always ready
        nvalid = 0; capw = -1;
        repeat (10) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (valid_a === 1'b1) begin nvalid++; capw = int'(width_a); caps = int'(sat_a); end
        end
        chk("meas_width", 32'(capw), 32'd10);
        chk("meas_sat", 32'(caps), 32'd0);
        chk("meas_valid_cycles", 32'(nvalid), 32'd1);

        // 40-cycle pulse saturates the 4-bit counter only
        capw = -1; capb = -1; caps = -1;
        repeat (40) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (valid_b === 1'b1) begin capb = int'(width_b); caps = int'(sat_b); capw = int'(width_a); end
        end
        chk("sat_width_b", 32'(capb), 32'd15);
        chk("sat_flag_b", 32'(caps), 32'd1);
        chk("sat_width_a", 32'(capw), 32'd40);

        // Backpressure: second result dropped, first retained
        repeat (5)  step(1'b0, 1'b0, 1'b0);
        repeat (8)  step(1'b1, 1'b0, 1'b0);
        repeat (7)  step(1'b0, 1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0, 1'b0);
        chk("bp_width", 32'(width_a), 32'd5);
        chk("bp_valid", 32'(valid_a), 32'd1);
        chk("bp_overrun", 32'(ovr_a), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("bp_after_xfer_valid", 32'(valid_a), 32'd0);
        chk("bp_ovr_still_set", 32'(ovr_a), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("bp_ovr_cleared", 32'(ovr_a), 32'd0);

        // Randomized pulses, gaps, sub-threshold glitches, ready and clear
        for (int it = 0; it < 40; it++) begin
            int len  = int'($urandom_range(F, 40));
            int h1   = int'($urandom_range(F, 8));
            int g    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, F - 1)) : 0;
            int h2   = int'($urandom_range(1, 4));
            repeat (len) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
            repeat (h1)  step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
            repeat (g)   step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
            repeat (h2)  step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end
        repeat (12) step(1'b1, 1'b1, 1'b1);

        // Leave a non-zero width behind, then reset asynchronously mid-pulse
        repeat (6)  step(1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b1, 1'b1, 1'b0);
        chk("pre_reset_width", 32'(width_a), 32'd6);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid_a", 32'(valid_a), 32'd0);
        chk("async_width_a", 32'(width_a), 32'd0);
        chk("async_width_b", 32'(width_b), 32'd0);
        chk("async_filt_a", 32'(filt_a), 32'd1);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        capw = -1;
        repeat (8) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (valid_a === 1'b1) capw = int'(width_a);
        end
        chk("post_reset_width", 32'(capw), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mioc_od_rx
